dmul_uni_acc: RTL and testbench

- Downstream consumer of the rotation-based unipolar deterministic multiplier.
- Sequences one multiply: drives the multiplier's load strobe, then counts 1s in its output bitstream over a fixed window of 2^WINLOG cycles.
- Returns the binary product with a one-cycle valid pulse.
- Sits between the multiplier's oC output and the binary datapath / test harness.

---
 rtl/dmul_uni_pkg.sv | 41 ++++
 rtl/dmul_uni_win_cnt.sv | 31 +++
 rtl/dmul_uni_acc.sv | 165 ++++++++++++++++
 tb/tb_dmul_uni_acc.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmul_uni_pkg.sv
// Shared types and helpers for the unipolar multiplier result accumulator.
// Holds the sequencer state encoding, the count-to-result scaling rule and
// the parameter legality check used by the accumulator at elaboration.
package dmul_uni_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } acc_state_t;

    // Working width of the scaling helper; wide enough for any legal WINLOG.
    localparam int CALC_W = 32;

    // Legal when the result fits inside the window bits and at least one
    // cycle separates the load strobe from the first valid stream bit.
    function automatic bit params_legal(input int winlog, input int outwd, input int lat);
        return (outwd >= 1) && (outwd <= winlog) && (winlog < CALC_W) && (lat >= 1);
    endfunction

    // A full-window count (every bit was 1) saturates to all ones; anything
    // else keeps the top outwd bits of the window-sized count (truncating).
    function automatic logic [CALC_W-1:0] scale_sat(input logic [CALC_W-1:0] count,
                                                    input int winlog,
                                                    input int outwd);
        logic [CALC_W-1:0] full_s;
        logic [CALC_W-1:0] mask_s;
        logic [CALC_W-1:0] res_s;
        full_s = 32'd1 << winlog;
        mask_s = (32'd1 << outwd) - 32'd1;
        if (count == full_s) begin
            res_s = mask_s;
        end else begin
            res_s = (count >> (winlog - outwd)) & mask_s;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/dmul_uni_win_cnt.sv
// Loadable down-counter with enable and terminal-count flag. The accumulator
// uses one instance to time the post-load wait and another for the window.
module dmul_uni_win_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_r;

    // Load has priority over counting; the count parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != '0)) begin
            count_r <= count_r - W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == '0);

endmodule

// File: rtl/dmul_uni_acc.sv
// Sequencer and ones-counter behind the rotation-based unipolar multiplier.
// Pulses the multiplier's load strobe, skips the pipeline latency, counts the
// 1s of its output stream over 2^WINLOG cycles and returns the scaled product.
module dmul_uni_acc
    import dmul_uni_pkg::*;
#(
    parameter int WINLOG = 16,
    parameter int OUTWD  = 8,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic              iBit,
    output logic              oLoad,
    output logic              oBusy,
    output logic              oValid,
    output logic [WINLOG:0]   oCnt,
    output logic [OUTWD-1:0]  oResult
);

    if (!params_legal(WINLOG, OUTWD, LAT)) begin : g_bad_params
        $error("dmul_uni_acc: need 1 <= OUTWD <= WINLOG and LAT >= 1");
    end

    // Wait counter holds LAT-2 so that WAIT spans LAT-1 cycles.
    localparam int                 WAIT_W    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'((LAT > 1) ? (LAT - 2) : 0);
    // Window counter holds 2^WINLOG-1 so that RUN spans 2^WINLOG cycles.
    localparam logic [WINLOG:0]    RUN_LOAD  = {1'b0, {WINLOG{1'b1}}};

    acc_state_t        state_r;
    acc_state_t        state_nx_s;
    logic              load_r;
    logic              busy_r;
    logic              valid_r;
    logic [WINLOG:0]   cnt_r;
    logic [WINLOG:0]   cnt_sum_s;
    logic [OUTWD-1:0]  result_r;
    logic              wait_tc_s;
    logic              run_tc_s;
    logic              wait_load_s;
    logic              wait_en_s;
    logic              run_load_s;
    logic              run_en_s;

    assign cnt_sum_s   = cnt_r + {{WINLOG{1'b0}}, iBit};
    assign wait_load_s = (state_r != S_WAIT);
    assign wait_en_s   = (state_r == S_WAIT);
    assign run_load_s  = (state_r != S_RUN);
    assign run_en_s    = (state_r == S_RUN);

    dmul_uni_win_cnt #(.W(WAIT_W)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (wait_load_s),
        .en       (wait_en_s),
        .load_val (WAIT_LOAD),
        .tc       (wait_tc_s)
    );

    dmul_uni_win_cnt #(.W(WINLOG + 1)) u_run_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (run_load_s),
        .en       (run_en_s),
        .load_val (RUN_LOAD),
        .tc       (run_tc_s)
    );

    // Next-state selection; abort beats start and every other transition.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (iStart && !iAbort) begin
                    state_nx_s = S_LOAD;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (iAbort) begin
                    state_nx_s = S_IDLE;
                end else if (LAT > 1) begin
                    state_nx_s = S_WAIT;
                end else begin
                    state_nx_s = S_RUN;
                end
            end
            S_WAIT: begin
                if (iAbort) begin
                    state_nx_s = S_IDLE;
                end else if (wait_tc_s) begin
                    state_nx_s = S_RUN;
                end else begin
                    state_nx_s = S_WAIT;
                end
            end
            S_RUN: begin
                if (iAbort) begin
                    state_nx_s = S_IDLE;
                end else if (run_tc_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_RUN;
                end
            end
            S_DONE: begin
                state_nx_s = S_IDLE;
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            load_r  <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            load_r  <= (state_nx_s == S_LOAD);
            busy_r  <= (state_nx_s == S_LOAD) || (state_nx_s == S_WAIT) ||
                       (state_nx_s == S_RUN);
            valid_r <= (state_nx_s == S_DONE);
        end
    end

    // Ones counter: cleared on load, accumulates in RUN, frozen on abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if ((state_r == S_IDLE) && (state_nx_s == S_LOAD)) begin
            cnt_r <= '0;
        end else if ((state_r == S_RUN) && (state_nx_s != S_IDLE)) begin
            cnt_r <= cnt_sum_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Result captured from the final count as the window closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= '0;
        end else if ((state_r == S_RUN) && (state_nx_s == S_DONE)) begin
            result_r <= OUTWD'(scale_sat(CALC_W'(cnt_sum_s), WINLOG, OUTWD));
        end else begin
            result_r <= result_r;
        end
    end

    assign oLoad   = load_r;
    assign oBusy   = busy_r;
    assign oValid  = valid_r;
    assign oCnt    = cnt_r;
    assign oResult = result_r;

endmodule

// File: tb/tb_dmul_uni_acc.sv
// Bench for dmul_uni_acc: two instances sharing stimulus (LAT=1 with a 4-bit
// result, LAT=3 with a 2-bit result, both 16-cycle windows) compared every
// cycle against a phase-count model, plus directed literal expectations.
module tb_dmul_uni_acc;

    localparam int NWLOG = 4;
    localparam int NW    = 16;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       ibit;

    logic       load_a, busy_a, valid_a;
    logic [4:0] cnt_a;
    logic [3:0] res_a;
    logic       load_b, busy_b, valid_b;
    logic [4:0] cnt_b;
    logic [1:0] res_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int tick_idx = 0;
    int va = 0;
    int vb = 0;
    int first_va = -1;
    int first_vb = -1;

    // Model state: phase since accepted start (0 = idle), count, result.
    int ph[2];
    int m_cnt[2];
    int m_res[2];

    dmul_uni_acc #(.WINLOG(NWLOG), .OUTWD(4), .LAT(1)) dut_a (
        .clk(clk), .rst(rst), .iStart(start), .iAbort(abort), .iBit(ibit),
        .oLoad(load_a), .oBusy(busy_a), .oValid(valid_a), .oCnt(cnt_a), .oResult(res_a)
    );

    dmul_uni_acc #(.WINLOG(NWLOG), .OUTWD(2), .LAT(3)) dut_b (
        .clk(clk), .rst(rst), .iStart(start), .iAbort(abort), .iBit(ibit),
        .oLoad(load_b), .oBusy(busy_b), .oValid(valid_b), .oCnt(cnt_b), .oResult(res_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int outwd_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    // Reference model: phase 1 is the load cycle, phases lat+1..lat+NW sample
    // the stream, phase lat+NW+1 presents the result, then back to idle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int lat, last, nph, ncnt, nres;
            lat  = lat_of(i);
            last = lat + NW;
            nph  = ph[i];
            ncnt = m_cnt[i];
            nres = m_res[i];
            if (rst) begin
                nph = 0; ncnt = 0; nres = 0;
            end else if (ph[i] == 0) begin
                if (start && !abort) begin
                    nph = 1; ncnt = 0;
                end
            end else if (ph[i] == last + 1) begin
                nph = 0;
            end else if (abort) begin
                nph = 0;
            end else begin
                if (ph[i] > lat) ncnt = ncnt + int'(ibit);
                if (ph[i] == last) begin
                    if (ncnt == NW) nres = (1 << outwd_of(i)) - 1;
                    else nres = ncnt >> (NWLOG - outwd_of(i));
                end
                nph = ph[i] + 1;
            end
            ph[i]    <= nph;
            m_cnt[i] <= ncnt;
            m_res[i] <= nres;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: move to the falling edge, log valid pulses, compare all outputs.
    task automatic tick();
        @(negedge clk);
        tick_idx++;
        if (valid_a) begin
            va++;
            if (first_va < 0) first_va = tick_idx;
        end
        if (valid_b) begin
            vb++;
            if (first_vb < 0) first_vb = tick_idx;
        end
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int last;
                last = lat_of(i) + NW;
                check($sformatf("load[%0d]", i), int'((i == 0) ? load_a : load_b), int'(ph[i] == 1));
                check($sformatf("busy[%0d]", i), int'((i == 0) ? busy_a : busy_b),
                      int'((ph[i] >= 1) && (ph[i] <= last)));
                check($sformatf("valid[%0d]", i), int'((i == 0) ? valid_a : valid_b),
                      int'(ph[i] == last + 1));
                check($sformatf("cnt[%0d]", i), (i == 0) ? int'(cnt_a) : int'(cnt_b), m_cnt[i]);
                check($sformatf("res[%0d]", i), (i == 0) ? int'(res_a) : int'(res_b), m_res[i]);
            end
        end
    endtask

    task automatic clear_log();
        tick_idx = 0; va = 0; vb = 0; first_va = -1; first_vb = -1;
    endtask

    // Pulse start for one cycle then run n more cycles.
    task automatic run_op(input int n);
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int dens;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ibit = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_cnt_a", int'(cnt_a), 0);
        check("reset_busy_b", int'(busy_b), 0);

        // All-ones stream: saturation and latency
        ibit = 1'b1;
        run_op(24);
        check("ones_lat_a", first_va, 18);
        check("ones_lat_b", first_vb, 20);
        check("ones_cnt_a", int'(cnt_a), 16);
        check("ones_res_a", int'(res_a), 15);
        check("ones_cnt_b", int'(cnt_b), 16);
        check("ones_res_b", int'(res_b), 3);

        // All-zero stream
        ibit = 1'b0;
        run_op(24);
        check("zero_cnt_a", int'(cnt_a), 0);
        check("zero_res_a", int'(res_a), 0);
        check("zero_res_b", int'(res_b), 0);

        // Ones only in the two cycles after LOAD: ignored while waiting
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ibit = 1'b1;
        tick();
        tick();
        ibit = 1'b0;
        for (int k = 0; k < 22; k++) tick();
        check("wait_cnt_a", int'(cnt_a), 2);
        check("wait_res_a", int'(res_a), 2);
        check("wait_cnt_b", int'(cnt_b), 0);
        check("wait_res_b", int'(res_b), 0);

        // Start re-pulsed during RUN and during DONE is ignored
        ibit = 1'b1;
        clear_log();
        start = 1'b1;
        tick();
        for (int k = 1; k <= 25; k++) begin
            start = (k == 7) || (k == 18);
            tick();
        end
        start = 1'b0;
        check("repulse_va", va, 1);
        check("repulse_vb", vb, 1);
        check("repulse_res_a", int'(res_a), 15);

        // Abort together with start in RUN
        ibit = 1'b0;
        run_op(5);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_busy_a", int'(busy_a), 0);
        check("abort_busy_b", int'(busy_b), 0);
        for (int k = 0; k < 20; k++) tick();
        check("abort_va", va, 0);
        check("abort_vb", vb, 0);
        check("abort_res_a", int'(res_a), 15);
        check("abort_res_b", int'(res_b), 3);

        // Reset on the 5th RUN cycle of the LAT=1 instance, then recover
        ibit = 1'b1;
        run_op(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_cnt_a", int'(cnt_a), 0);
        check("rst_res_a", int'(res_a), 0);
        check("rst_cnt_b", int'(cnt_b), 0);
        run_op(24);
        check("recover_cnt_a", int'(cnt_a), 16);
        check("recover_res_a", int'(res_a), 15);
        check("recover_res_b", int'(res_b), 3);

        // Randomized traffic against the model
        dens = 2;
        for (int k = 0; k < 3000; k++) begin
            if ((k % 150) == 0) dens = int'($urandom_range(0, 4));
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 59) == 0);
            rst   = ($urandom_range(0, 399) == 0);
            ibit  = (int'($urandom_range(0, 3)) < dens);
            tick();
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
